// File: rtl/imem_loader_ctrl.sv
// Instruction-memory port owner: arbitrates the single address/write port between
// the program loader and CPU fetch, sequences core reset, and detects self-loop halt.
module imem_loader_ctrl #(
  parameter int                    WIDTH      = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [WIDTH-1:0]      HALT_INSTR = 32'h00000063,
  parameter logic [WIDTH-1:0]      NOP_INSTR  = 32'h00000013,
  localparam int                   ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [WIDTH-1:0]       ld_data,
  input  logic                   ld_last,
  input  logic                   run_req,
  input  logic                   reload,
  input  logic [WIDTH-1:0]       cpu_pc,
  output logic [WIDTH-1:0]       cpu_instr,
  output logic                   cpu_rst_n,
  output logic                   mem_we,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic [WIDTH-1:0]       mem_rdata,
  output logic [1:0]             state,
  output logic                   halted,
  output logic [ADDR_BITS:0]     load_count,
  output logic                   err_overflow,
  output logic                   err_fetch
);

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  localparam logic [ADDR_BITS:0] FULL     = (ADDR_BITS+1)'(DEPTH);
  localparam logic [WIDTH:0]     PC_LIMIT = (WIDTH+1)'(4 * DEPTH);

  state_e               state_q;
  logic [ADDR_BITS:0]   cnt_q;
  logic                 cpu_rst_n_q;
  logic                 err_ovf_q;
  logic                 err_fetch_q;
  logic [WIDTH-1:0]     prev_pc_q;
  logic                 prev_halt_q;

  logic in_load, in_run, in_halt, full, accept, pc_bad, fetch_fault, halt_hit, start_run;

  always_comb begin
    in_load     = (state_q == S_LOAD);
    in_run      = (state_q == S_RUN);
    in_halt     = (state_q == S_HALT);
    full        = (cnt_q >= FULL);
    ld_ready    = in_load & ~full & ~reload;
    accept      = ld_ready & ld_valid;
    mem_we      = accept;
    mem_wdata   = ld_data;
    mem_addr    = in_load ? cnt_q[ADDR_BITS-1:0] : cpu_pc[ADDR_BITS+1:2];
    pc_bad      = (cpu_pc[1:0] != 2'b00) | ({1'b0, cpu_pc} >= PC_LIMIT);
    // Fetch faults only count once the core is out of reset and actually fetching.
    fetch_fault = in_run & cpu_rst_n_q & pc_bad;
    cpu_instr   = NOP_INSTR;
    if (in_run && !fetch_fault) cpu_instr = mem_rdata;
    else if (in_halt)           cpu_instr = HALT_INSTR;
    halt_hit    = in_run & ~fetch_fault & (cpu_instr == HALT_INSTR) &
                  prev_halt_q & (cpu_pc == prev_pc_q);
    start_run   = in_load & ((accept & ld_last) | (run_req & (cnt_q != '0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_fetch_q <= 1'b0;
      prev_pc_q   <= '0;
      prev_halt_q <= 1'b0;
    end else if (reload) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      prev_halt_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          cpu_rst_n_q <= 1'b0;
          if (accept)            cnt_q     <= cnt_q + 1'b1;
          if (ld_valid && full)  err_ovf_q <= 1'b1;
          if (start_run) begin
            state_q     <= S_RUN;
            prev_halt_q <= 1'b0;
          end
        end
        S_RUN: begin
          // Core leaves reset on the first edge spent in RUN.
          cpu_rst_n_q <= 1'b1;
          prev_pc_q   <= cpu_pc;
          prev_halt_q <= (cpu_instr == HALT_INSTR);
          if (fetch_fault) begin
            err_fetch_q <= 1'b1;
            state_q     <= S_HALT;
          end else if (halt_hit) begin
            state_q     <= S_HALT;
          end
        end
        S_HALT: begin
          if (run_req) begin
            state_q     <= S_RUN;
            cpu_rst_n_q <= 1'b0;
            prev_halt_q <= 1'b0;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign state        = state_q;
  assign halted       = in_halt;
  assign load_count   = cnt_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign err_overflow = err_ovf_q;
  assign err_fetch    = err_fetch_q;

endmodule
